// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the immediate encoder / load-immediate sequencer.
package riscv_pkg;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} seq_state_t;

   // True when v sign-extends from 12 bits, i.e. lies in [-2048, 2047].
   function automatic logic fits_simm12(input logic [31:0] v);
      return (v[31:11] == '0) || (v[31:11] == '1);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Packs a 32-bit immediate into the immediate fields of a template instruction
// (inverse of the immediate extender) and flags unrepresentable values.
module imm_pack
   import riscv_pkg::*;
(
   input  logic [31:0] base,
   input  logic [2:0]  fmt,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        err
);

   logic fit12, fit13, fit21;

   // Odd values are rejected separately, so the upper bounds 4094 / 2^20-2
   // fall out of a plain sign-extension test.
   assign fit12 = fits_simm12(imm);
   assign fit13 = (imm[31:12] == '0) || (imm[31:12] == '1);
   assign fit21 = (imm[31:20] == '0) || (imm[31:20] == '1);

   always_comb begin
      instr = base;
      err   = 1'b0;
      case (fmt)
         IMM_I: begin
            instr[31:20] = imm[11:0];
            err          = !fit12;
         end
         IMM_S: begin
            instr[31:25] = imm[11:5];
            instr[11:7]  = imm[4:0];
            err          = !fit12;
         end
         IMM_B: begin
            instr[31]    = imm[12];
            instr[7]     = imm[11];
            instr[30:25] = imm[10:5];
            instr[11:8]  = imm[4:1];
            err          = !fit13 || imm[0];
         end
         IMM_J: begin
            instr[31]    = imm[20];
            instr[19:12] = imm[19:12];
            instr[20]    = imm[11];
            instr[30:21] = imm[10:1];
            err          = !fit21 || imm[0];
         end
         IMM_U: begin
            instr[31:12] = imm[31:12];
            err          = (imm[11:0] != '0);
         end
         default: err = 1'b1;
      endcase
      if (err)
         instr = base;
   end

endmodule

// File: rtl/imm_encode_seq.sv
// Immediate encoder and load-immediate sequencer: ENCODE packs one instruction,
// LI expands a constant into ADDI, LUI or LUI+ADDI beats over valid/ready.
module imm_encode_seq
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_op,
   input  logic [2:0]  in_fmt,
   input  logic [31:0] in_base,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_last,
   output logic        out_err
);

   seq_state_t  state;
   logic [31:0] beat2;

   logic [31:0] pk_instr;
   logic        pk_err;

   imm_pack u_pack (
      .base  (in_base),
      .fmt   (in_fmt),
      .imm   (in_imm),
      .instr (pk_instr),
      .err   (pk_err)
   );

   logic [11:0] lo;
   logic [19:0] hi;
   logic [31:0] addi_x0, addi_rd, lui;

   // hi rounds up when lo is negative so that LUI hi + ADDI lo lands on imm.
   assign lo      = in_imm[11:0];
   assign hi      = in_imm[31:12] + {19'd0, in_imm[11]};
   assign addi_x0 = {lo, 5'd0, 3'b000, in_rd, OP_IMM};
   assign addi_rd = {lo, in_rd, 3'b000, in_rd, OP_IMM};
   assign lui     = {hi, in_rd, OP_LUI};

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beat2     <= '0;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_last  <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state     <= BEAT1;
                  out_valid <= 1'b1;
                  beat2     <= addi_rd;
                  if (!in_op) begin
                     out_instr <= pk_instr;
                     out_err   <= pk_err;
                     out_last  <= 1'b1;
                  end else begin
                     out_err <= 1'b0;
                     if (fits_simm12(in_imm)) begin
                        out_instr <= addi_x0;
                        out_last  <= 1'b1;
                     end else begin
                        out_instr <= lui;
                        out_last  <= (lo == '0);
                     end
                  end
               end
            end
            BEAT1: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                  end else begin
                     state     <= BEAT2;
                     out_instr <= beat2;
                     out_last  <= 1'b1;
                  end
               end
            end
            BEAT2: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imm_encode_seq.sv
// Self-checking bench for imm_encode_seq: directed plan cases plus randomized
// ENCODE/LI requests checked against an extender-based reference model.
module tb_imm_encode_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_op;
   logic [2:0]  in_fmt;
   logic [31:0] in_base;
   logic [4:0]  in_rd;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic        out_err;

   int total = 0;
   int bad   = 0;

   logic [31:0] got_i[$];
   logic        got_l[$];
   logic        got_e[$];
   int          got_lat;
   int          got_unstable;
   bit          got_tmo;

   imm_encode_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_fmt    (in_fmt),
      .in_base   (in_base),
      .in_rd     (in_rd),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_last  (out_last),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit ref_err(input logic [2:0] f, input logic [31:0] v);
      int s;
      s = int'(v);
      case (f)
         3'd0, 3'd1: return (s < -2048) || (s > 2047);
         3'd2:       return (s < -4096) || (s > 4094) || v[0];
         3'd3:       return (s < -1048576) || (s > 1048574) || v[0];
         3'd4:       return (v[11:0] != 12'd0);
         default:    return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] ref_mask(input logic [2:0] f);
      case (f)
         3'd0:       return 32'hFFF0_0000;
         3'd1, 3'd2: return 32'hFE00_0F80;
         default:    return 32'hFFFF_F000;
      endcase
   endfunction

   // Standard RV32I immediate extender.
   function automatic logic [31:0] ref_ext(input logic [2:0] f, input logic [31:0] i);
      case (f)
         3'd0:    return {{20{i[31]}}, i[31:20]};
         3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return {i[31:12], 12'd0};
      endcase
   endfunction

   function automatic logic [31:0] pick_imm(input int unsigned mode);
      logic [31:0] v;
      case (mode)
         0: v = $urandom;
         1: v = 32'($urandom_range(8191)) - 32'd4096;
         2: v = 32'($urandom_range(32'h3F_FFFF)) - 32'h20_0000;
         3: v = $urandom & 32'hFFFF_F000;
         default: begin
            case ($urandom_range(13))
               0: v = 32'd2047;        1: v = 32'd2048;
               2: v = -32'sd2048;      3: v = -32'sd2049;
               4: v = 32'd4094;        5: v = 32'd4095;
               6: v = -32'sd4096;      7: v = -32'sd4098;
               8: v = 32'h000F_FFFE;   9: v = 32'h0010_0000;
               10: v = 32'hFFF0_0000;  11: v = 32'hFFEF_FFFE;
               12: v = 32'h0000_0800;  default: v = 32'd0;
            endcase
         end
      endcase
      return v;
   endfunction

   // ---------------- stimulus / collection ----------------
   task automatic run_req(input logic op, input logic [2:0] fmt, input logic [31:0] base,
                          input logic [4:0] rd, input logic [31:0] imm, input int unsigned stall_pct);
      bit done, hold, r;
      int waited;
      logic [31:0] pi;
      logic pl, pe;
      got_i.delete(); got_l.delete(); got_e.delete();
      got_lat = -1; got_unstable = 0;
      done = 0; hold = 0; waited = 0;
      pi = '0; pl = 0; pe = 0;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_fmt = fmt; in_base = base; in_rd = rd; in_imm = imm;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_op = $urandom; in_fmt = 3'($urandom); in_base = $urandom;
      in_rd = 5'($urandom); in_imm = $urandom;
      while (!done && waited < 40) begin
         @(negedge clk);
         if (out_valid && got_lat < 0) got_lat = waited;
         if (hold && (out_instr !== pi || out_last !== pl || out_err !== pe)) got_unstable++;
         r = ($urandom_range(99) >= stall_pct);
         out_ready = r;
         if (out_valid && r) begin
            got_i.push_back(out_instr);
            got_l.push_back(out_last);
            got_e.push_back(out_err);
            if (out_last) done = 1;
         end
         hold = out_valid && !r;
         pi = out_instr; pl = out_last; pe = out_err;
         waited++;
      end
      got_tmo = !done;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      #2;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_instr !== 32'd0 ||
          out_last !== 1'b0 || out_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got rdy=%b vld=%b instr=%h last=%b err=%b want rdy=1 vld=0 instr=0 last=0 err=0",
                  in_ready, out_valid, out_instr, out_last, out_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_encode_directed;
      logic [31:0] want_i[6];
      logic        want_e[6];
      logic [2:0]  f[6];
      logic [31:0] b[6];
      logic [31:0] v[6];
      f[0] = 3'd0; b[0] = 32'h0000_0513; v[0] = 32'hFFFF_FFFF; want_i[0] = 32'hFFF0_0513; want_e[0] = 0;
      f[1] = 3'd2; b[1] = 32'h00B5_0463; v[1] = 32'd3;         want_i[1] = 32'h00B5_0463; want_e[1] = 1;
      f[2] = 3'd3; b[2] = 32'h0000_00EF; v[2] = 32'h000F_FFFE; want_i[2] = 32'h7FFF_F0EF; want_e[2] = 0;
      f[3] = 3'd1; b[3] = 32'h00A1_2023; v[3] = 32'hFFFF_FFFC; want_i[3] = 32'hFEA1_2E23; want_e[3] = 0;
      f[4] = 3'd4; b[4] = 32'h0000_0537; v[4] = 32'h1234_5000; want_i[4] = 32'h1234_5537; want_e[4] = 0;
      f[5] = 3'd5; b[5] = 32'hDEAD_BEEF; v[5] = 32'd0;         want_i[5] = 32'hDEAD_BEEF; want_e[5] = 1;
      for (int k = 0; k < 6; k++) begin
         run_req(1'b0, f[k], b[k], 5'd0, v[k], 0);
         total++;
         if (got_tmo || got_i.size() != 1 || got_lat != 0) begin
            bad++;
            $display("FAIL enc_dir%0d_beats: got tmo=%0d beats=%0d lat=%0d want tmo=0 beats=1 lat=0",
                     k, got_tmo, got_i.size(), got_lat);
         end else begin
            total++;
            if (got_i[0] !== want_i[k] || got_e[0] !== want_e[k] || got_l[0] !== 1'b1) begin
               bad++;
               $display("FAIL enc_dir%0d: got instr=%h err=%b last=%b want instr=%h err=%b last=1",
                        k, got_i[0], got_e[0], got_l[0], want_i[k], want_e[k]);
            end
         end
      end
      // the J case must round-trip through the extender
      total++;
      if (ref_ext(3'd3, 32'h7FFF_F0EF) !== 32'h000F_FFFE || got_tmo) begin
         bad++;
         $display("FAIL enc_j_roundtrip: got %h want 000ffffe", ref_ext(3'd3, 32'h7FFF_F0EF));
      end
   endtask

   task automatic test_encode_random;
      logic [2:0]  f;
      logic [31:0] b, v, m;
      bit          e;
      for (int n = 0; n < 80; n++) begin
         f = 3'($urandom_range(7));
         b = $urandom;
         v = pick_imm($urandom_range(4));
         e = ref_err(f, v);
         m = ref_mask(f);
         run_req(1'b0, f, b, 5'($urandom), v, 30);
         total++;
         if (got_tmo || got_i.size() != 1 || got_lat != 0 || got_unstable != 0) begin
            bad++;
            $display("FAIL enc_rnd%0d_beats: got tmo=%0d beats=%0d lat=%0d unstable=%0d want 0/1/0/0",
                     n, got_tmo, got_i.size(), got_lat, got_unstable);
            continue;
         end
         total++;
         if (got_e[0] !== e || got_l[0] !== 1'b1) begin
            bad++;
            $display("FAIL enc_rnd%0d_err: fmt=%0d imm=%h got err=%b last=%b want err=%b last=1",
                     n, f, v, got_e[0], got_l[0], e);
         end
         total++;
         if (e) begin
            if (got_i[0] !== b) begin
               bad++;
               $display("FAIL enc_rnd%0d_base: got %h want %h", n, got_i[0], b);
            end
         end else if (((got_i[0] ^ b) & ~m) != 32'd0 || ref_ext(f, got_i[0]) !== v) begin
            bad++;
            $display("FAIL enc_rnd%0d_pack: fmt=%0d imm=%h base=%h got %h (ext=%h) want ext=%h",
                     n, f, v, b, got_i[0], ref_ext(f, got_i[0]), v);
         end
         total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL enc_rnd%0d_idle: got rdy=%b vld=%b want 1/0", n, in_ready, out_valid);
         end
      end
   endtask

   task automatic li_check(input string tag, input logic [4:0] rd, input logic [31:0] v,
                           input int unsigned stall);
      logic [31:0] exp_q[$];
      logic [11:0] lo;
      logic [19:0] hi;
      logic [31:0] sum, regv, ins;
      int s;
      s = int'(v);
      lo = v[11:0];
      sum = v + 32'h800;
      hi = sum[31:12];
      if (s >= -2048 && s <= 2047)
         exp_q.push_back({lo, 5'd0, 3'b000, rd, 7'b0010011});
      else begin
         exp_q.push_back({hi, rd, 7'b0110111});
         if (lo != 12'd0) exp_q.push_back({lo, rd, 3'b000, rd, 7'b0010011});
      end
      run_req(1'b1, 3'($urandom), $urandom, rd, v, stall);
      total++;
      if (got_tmo || got_i.size() != exp_q.size() || got_lat != 0 || got_unstable != 0) begin
         bad++;
         $display("FAIL %s_beats: imm=%h got tmo=%0d beats=%0d lat=%0d unstable=%0d want tmo=0 beats=%0d lat=0 unstable=0",
                  tag, v, got_tmo, got_i.size(), got_lat, got_unstable, exp_q.size());
         return;
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         total++;
         if (got_i[k] !== exp_q[k] || got_l[k] !== (k == exp_q.size() - 1) || got_e[k] !== 1'b0) begin
            bad++;
            $display("FAIL %s_beat%0d: imm=%h got instr=%h last=%b err=%b want instr=%h last=%b err=0",
                     tag, k, v, got_i[k], got_l[k], got_e[k], exp_q[k], k == exp_q.size() - 1);
         end
      end
      if (rd != 5'd0) begin
         regv = 32'd0;
         foreach (got_i[k]) begin
            ins = got_i[k];
            if (ins[6:0] == 7'b0110111) regv = {ins[31:12], 12'd0};
            else regv = ((ins[19:15] == 5'd0) ? 32'd0 : regv) + {{20{ins[31]}}, ins[31:20]};
         end
         total++;
         if (regv !== v) begin
            bad++;
            $display("FAIL %s_exec: executed value %h want %h", tag, regv, v);
         end
      end
   endtask

   task automatic test_li_directed;
      li_check("li_12345678", 5'd10, 32'h1234_5678, 0);
      li_check("li_fff",      5'd10, 32'h0000_0FFF, 0);
      li_check("li_5000",     5'd10, 32'h0000_5000, 0);
      li_check("li_neg1",     5'd10, 32'hFFFF_FFFF, 0);
      li_check("li_x0",       5'd0,  32'h8000_0801, 0);
   endtask

   task automatic test_li_random;
      for (int n = 0; n < 80; n++)
         li_check($sformatf("li_rnd%0d", n), 5'($urandom), pick_imm($urandom_range(4)), 40);
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      in_valid = 1'b1; in_op = 1'b1; in_rd = 5'd10; in_imm = 32'h1234_5678; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0; in_imm = 32'h0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_instr !== 32'h1234_5537 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: got vld=%b instr=%h last=%b rdy=%b want 1/12345537/0/0",
                     c, out_valid, out_instr, out_last, in_ready);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_instr !== 32'h6785_0513 || out_last !== 1'b1 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_beat2: got vld=%b instr=%h last=%b rdy=%b want 1/67850513/1/0",
                  out_valid, out_instr, out_last, in_ready);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_done: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      in_valid = 1'b1; in_op = 1'b0; in_fmt = 3'd0; in_base = 32'h0000_0013; in_imm = 32'd5;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== ((c % 2) == 0) || in_ready !== ((c % 2) == 1)) begin
            bad++;
            $display("FAIL b2b_cycle%0d: got vld=%b rdy=%b want vld=%b rdy=%b",
                     c, out_valid, in_ready, (c % 2) == 0, (c % 2) == 1);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      in_valid = 1'b1; in_op = 1'b1; in_rd = 5'd10; in_imm = 32'h1234_5678; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_instr !== 32'h6785_0513) begin
         bad++;
         $display("FAIL rst_mid_pending: got vld=%b instr=%h want 1/67850513", out_valid, out_instr);
      end
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'd0 || out_last !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_clear: got vld=%b rdy=%b instr=%h last=%b want 0/1/0/0",
                  out_valid, in_ready, out_instr, out_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_stray%0d: got vld=%b rdy=%b want 0/1", c, out_valid, in_ready);
         end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_fmt = 3'd0; in_base = '0;
      in_rd = '0; in_imm = '0; out_ready = 1'b0;
      test_reset;
      test_encode_directed;
      test_encode_random;
      test_li_directed;
      test_li_random;
      test_backpressure;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imm_encode_seq.md
# imm_encode_seq

Immediate encoder and load-immediate sequencer for the RISCV32I datapath; it performs the inverse of the immediate extender. Given a 32-bit immediate and an ImmSrc-coded format, it packs the immediate into the instruction's immediate fields and flags values that cannot be represented. In LI mode it expands a 32-bit constant into one or two instructions, ADDI, LUI, or LUI+ADDI, and streams them out over a valid/ready handshake. It feeds the instruction-patch and self-test paths that write instruction memory.

## Interface
- No parameters. Widths are fixed at RV32.
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  1  0 = ENCODE, 1 = LI
- in_fmt  in  3  ImmSrc code: 0 = I, 1 = S, 2 = B, 3 = J, 4 = U; 5–7 are illegal; ignored when in_op = LI
- in_base  in  32  template instruction; its immediate fields are overwritten; ignored when in_op = LI
- in_rd  in  5  destination register; LI only
- in_imm  in  32  immediate value
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_instr  out  32  encoded instruction
- out_last  out  1  final beat of the request
- out_err  out  1  immediate not representable; ENCODE only

## Operation
- States:
  - IDLE: in_ready = 1.
  - BEAT1: first output beat is held.
  - BEAT2: second output beat is held; LI only.
- Accept (IDLE, in_valid = 1):
  - Latch the request.
  - Load the output register with beat 1.
  - Go to BEAT1.
- ENCODE field packing; all other base bits pass through unchanged:
  - I: [31:20] = imm[11:0].
  - S: [31:25] = imm[11:5], [11:7] = imm[4:0].
  - B: [31] = imm[12], [7] = imm[11], [30:25] = imm[10:5], [11:8] = imm[4:1].
  - J: [31] = imm[20], [19:12] = imm[19:12], [20] = imm[11], [30:21] = imm[10:1].
  - U: [31:12] = imm[31:12].
- out_err = 1 (signed compare) when:
  - I or S: imm is outside [-2048, 2047].
  - B: imm is outside [-4096, 4094], or imm[0] = 1.
  - J: imm is outside [-2^20, 2^20-2], or imm[0] = 1.
  - U: imm[11:0] != 0.
  - fmt is 5–7.
- On out_err = 1, out_instr = in_base unmodified.
- ENCODE is always a single beat with out_last = 1.
- LI expansion (lo = imm[11:0]; hi = (imm + 32'h800)[31:12], 32-bit modulo add):
  - If imm is in [-2048, 2047]: one beat, ADDI rd, x0, lo.
  - Else if lo = 0: one beat, LUI rd, hi.
  - Else: two beats, LUI rd, hi, then ADDI rd, rd, lo.
- LI out_err is always 0. In LI mode rd = x0 is encoded as given.
- Encodings:
  - ADDI = {lo, rs1, 3'b000, rd, 7'b0010011}.
  - LUI = {hi, rd, 7'b0110111}.
- Invariant: whenever out_err = 0, the extender applied to out_instr with the same format reproduces in_imm.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_instr = 0, out_last = 0, out_err = 0.
- Beat 1 is valid in the cycle after accept; latency is 1 cycle.
- out_instr, out_last and out_err are registered outputs. They stay stable while out_valid && !out_ready.
- Beat handshake (out_valid && out_ready):
  - Non-last beat: beat 2 is loaded and state goes BEAT1 -> BEAT2; out_valid stays 1.
  - Last beat: state goes to IDLE and out_valid = 0 in the next cycle.
- in_ready = 1 only in IDLE. No request is accepted in the same cycle as a last-beat handshake. Peak throughput is one request per 2 cycles.
- in_* inputs are sampled only on accept; changes at any other time are ignored.
- Reset asserted mid-sequence, including between the LUI and ADDI beats, immediately clears all state and outputs. The pending beat is dropped.

## Structure
- Shared package riscv_pkg holds:
  - ImmSrc codes IMM_I = 0, IMM_S = 1, IMM_B = 2, IMM_J = 3, IMM_U = 4.
  - Opcodes OP_IMM = 7'b0010011 and OP_LUI = 7'b0110111.
  - The state enum {IDLE, BEAT1, BEAT2}.
- One combinational sub-module, imm_pack, instantiated once: (base, fmt, imm) -> (instr, err).
- The sequencer module holds the FSM, the LI split logic and the output register.

## Test plan
- ENCODE I, base 32'h00000513, imm -1 -> out_instr 32'hFFF00513, err 0, last 1, valid in the cycle after accept.
- LI rd = 10, imm 32'h12345678 -> beat 32'h12345537 (last 0), then beat 32'h67850513 (last 1).
- LI rd = 10, imm 32'h00000FFF -> 32'h00001537, then 32'hFFF50513 (hi rounding case). LI rd = 10, imm 32'h00005000 -> single beat 32'h00005537, last 1.
- ENCODE B, imm 3 -> err 1, out_instr = base. ENCODE J, imm 32'h000FFFFE -> err 0, and the extender round-trips to 32'h000FFFFE.
- Backpressure: out_ready held low 3 cycles during LI beat 1 -> out_instr stable, in_ready 0; the release walks through both beats in order.
- rst_n pulsed low while LI beat 2 is pending -> out_valid 0, in_ready 1 immediately; no stray beat after release.
